// File: rtl/led_fade_pwm.sv
// PWM LED driver with a linear comet-tail fade: lit channels jump to full brightness and decay after going dark.
// Optional build macro LED_FADE_GAMMA_EN swaps the linear compare level for a squared perceptual curve.
module led_fade_pwm #(
  parameter int unsigned N_LED      = 16,
  parameter int unsigned BW         = 4,
  parameter int unsigned PWM_DIV    = 1000,
  parameter int unsigned DECAY_DIV  = 2_500_000,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_LED-1:0] led_in,
  output logic [N_LED-1:0] led_out,
  output logic             pwm_wrap
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [BW-1:0]    MAX      = {BW{1'b1}};
  localparam logic [BW-1:0]    PWM_LAST = MAX - 1'b1;
  localparam logic [BW-1:0]    STEP     = BW'(DECAY_STEP);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [BW-1:0]    pwm_cnt;
  logic [DEC_W-1:0] dec_cnt;
  logic             slice_tick;
  logic             decay_tick;
  logic [BW-1:0]    lvl [N_LED];
  logic [BW-1:0]    eff [N_LED];
  logic [N_LED-1:0] cmp;

  assign slice_tick = (pre_cnt == PRE_LAST);
  assign decay_tick = (dec_cnt == DEC_LAST);

  // Timebase: all three counters free-run regardless of en so bypass never disturbs the PWM phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      dec_cnt  <= '0;
      pwm_wrap <= 1'b0;
    end else begin
      pre_cnt  <= slice_tick ? '0 : pre_cnt + 1'b1;
      dec_cnt  <= decay_tick ? '0 : dec_cnt + 1'b1;
      pwm_wrap <= slice_tick && (pwm_cnt == PWM_LAST);
      if (slice_tick) begin
        pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      end
    end
  end

  // Brightness: a lit input reloads full scale even on a decay tick; decay saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_LED); i++) begin
        lvl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_LED); i++) begin
        if (!en) begin
          lvl[i] <= '0;
        end else if (led_in[i]) begin
          lvl[i] <= MAX;
        end else if (decay_tick) begin
          lvl[i] <= (lvl[i] <= STEP) ? '0 : lvl[i] - STEP;
        end
      end
    end
  end

`ifdef LED_FADE_GAMMA_EN
  function automatic logic [BW-1:0] gamma_of(input logic [BW-1:0] l);
    logic [2*BW-1:0] sq;
    sq = {{BW{1'b0}}, l} * {{BW{1'b0}}, l};
    if (l == MAX) begin
      return MAX;
    end
    return BW'(sq >> BW);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(N_LED); i++) begin
      eff[i] = gamma_of(lvl[i]);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < int'(N_LED); i++) begin
      eff[i] = lvl[i];
    end
  end
`endif

  // Full scale beats every slice value (max MAX-1), so lvl == MAX is steady on and lvl == 0 steady off.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      cmp[i] = (eff[i] > pwm_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
    end else begin
      led_out <= en ? cmp : led_in;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm: two instances (slow and fast decay) checked every cycle against a cycle model.
// Honours LED_FADE_GAMMA_EN for the expected compare curve.
module tb_led_fade_pwm;

  localparam int MAXV  = 15;
  localparam int DIV_A = 1000;
  localparam int DIV_B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] led_in;
  logic [15:0] led_out_a;
  logic [15:0] led_out_b;
  logic        wrap_a;
  logic        wrap_b;

  always #5 clk = ~clk;

  led_fade_pwm #(
    .N_LED(16), .BW(4), .PWM_DIV(1), .DECAY_DIV(DIV_A), .DECAY_STEP(1)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .led_in(led_in), .led_out(led_out_a), .pwm_wrap(wrap_a)
  );

  led_fade_pwm #(
    .N_LED(16), .BW(4), .PWM_DIV(1), .DECAY_DIV(DIV_B), .DECAY_STEP(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .led_in(led_in), .led_out(led_out_b), .pwm_wrap(wrap_b)
  );

  typedef struct packed {
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        wrap_a;
    logic        wrap_b;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  int m_pwm;
  int m_dec_a;
  int m_dec_b;
  int m_lvl_a[16];
  int m_lvl_b[16];

  function automatic int eff_of(input int l);
`ifdef LED_FADE_GAMMA_EN
    if (l == MAXV) return MAXV;
    return (l * l) / 16;
`else
    return l;
`endif
  endfunction

  function automatic int next_lvl(input int l, input logic load, input logic tick);
    if (!en) return 0;
    if (load) return MAXV;
    if (tick) return (l > 0) ? l - 1 : 0;
    return l;
  endfunction

  function automatic void model_reset();
    m_pwm   = 0;
    m_dec_a = 0;
    m_dec_b = 0;
    for (int i = 0; i < 16; i++) begin
      m_lvl_a[i] = 0;
      m_lvl_b[i] = 0;
    end
  endfunction

  // One clock: predict the post-edge outputs from the model, queue them, advance, then pop and compare.
  task automatic step();
    exp_t e;
    logic tick_a;
    logic tick_b;
    tick_a = (m_dec_a == DIV_A - 1);
    tick_b = (m_dec_b == DIV_B - 1);
    for (int i = 0; i < 16; i++) begin
      e.out_a[i] = en ? (eff_of(m_lvl_a[i]) > m_pwm) : led_in[i];
      e.out_b[i] = en ? (eff_of(m_lvl_b[i]) > m_pwm) : led_in[i];
    end
    e.wrap_a = (m_pwm == MAXV - 1);
    e.wrap_b = (m_pwm == MAXV - 1);
    sb.push_back(e);
    for (int i = 0; i < 16; i++) begin
      m_lvl_a[i] = next_lvl(m_lvl_a[i], led_in[i], tick_a);
      m_lvl_b[i] = next_lvl(m_lvl_b[i], led_in[i], tick_b);
    end
    m_pwm   = (m_pwm == MAXV - 1) ? 0 : m_pwm + 1;
    m_dec_a = tick_a ? 0 : m_dec_a + 1;
    m_dec_b = tick_b ? 0 : m_dec_b + 1;
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    n_vec++;
    if ({led_out_a, led_out_b, wrap_a, wrap_b} !== e) begin
      n_err++;
      $display("[TB] FAIL sb_outputs cycle=%0d got a=%h b=%h wrap=%b%b exp a=%h b=%h wrap=%b%b",
               cyc, led_out_a, led_out_b, wrap_a, wrap_b, e.out_a, e.out_b, e.wrap_a, e.wrap_b);
    end
  endtask

  task automatic wait_wrap(input string tag);
    for (int k = 0; k < 20; k++) begin
      step();
      if (wrap_a === 1'b1) return;
    end
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s_wrap_timeout got no pwm_wrap in 20 cycles, need one", tag);
  endtask

  task automatic count_high(input int ch, input int n, output int hi_a, output int hi_b,
                            output logic [15:0] others);
    hi_a   = 0;
    hi_b   = 0;
    others = '0;
    for (int k = 0; k < n; k++) begin
      step();
      if (led_out_a[ch]) hi_a++;
      if (led_out_b[ch]) hi_b++;
      others = others | (led_out_a & ~(16'h0001 << ch));
    end
  endtask

  task automatic count_first_wrap(input string tag);
    int first;
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      step();
      if (wrap_a === 1'b1) first = k;
    end
    n_vec++;
    if (first !== 15) begin
      n_err++;
      $display("[TB] FAIL %s_first_wrap got cycle %0d, need 15", tag, first);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    en     = 1'b0;
    led_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({led_out_a, led_out_b, wrap_a, wrap_b} !== 34'd0) begin
      n_err++;
      $display("[TB] FAIL reset_state got a=%h b=%h wrap=%b%b, need all 0",
               led_out_a, led_out_b, wrap_a, wrap_b);
    end
    en  = 1'b1;
    rst = 1'b0;
    model_reset();
    count_first_wrap("reset");
  endtask

  task automatic test_fade();
    int hi_a, hi_b, guard;
    logic [15:0] oth;
    led_in = 16'h0008;
    step();
    led_in = '0;
    wait_wrap("fade_full");
    count_high(3, 15, hi_a, hi_b, oth);
    n_vec++;
    if (hi_a !== 15) begin
      n_err++;
      $display("[TB] FAIL fade_full_period got %0d high cycles, need 15", hi_a);
    end
    n_vec++;
    if (oth !== 16'h0000) begin
      n_err++;
      $display("[TB] FAIL fade_other_channels got %h, need 0000", oth);
    end
    guard = 0;
    while (m_lvl_a[3] != 14 && guard < 1100) begin
      step();
      guard++;
    end
    wait_wrap("fade_14");
    count_high(3, 15, hi_a, hi_b, oth);
    n_vec++;
    if (hi_a !== 14) begin
      n_err++;
      $display("[TB] FAIL fade_after_decay got %0d high cycles, need 14", hi_a);
    end
  endtask

  task automatic test_underflow();
    int hi_a, hi_b;
    logic [15:0] oth;
    led_in = 16'h0001;
    step();
    led_in = '0;
    repeat (70) step();
    count_high(0, 30, hi_a, hi_b, oth);
    n_vec++;
    if (hi_b !== 0) begin
      n_err++;
      $display("[TB] FAIL underflow_hold_zero got %0d high cycles, need 0", hi_b);
    end
  endtask

  task automatic test_load_beats_decay();
    int hi_a, hi_b;
    logic [15:0] oth;
    led_in = 16'h0020;
    repeat (2) step();
    count_high(5, 20, hi_a, hi_b, oth);
    n_vec++;
    if (hi_b !== 20) begin
      n_err++;
      $display("[TB] FAIL load_beats_decay_b got %0d high cycles, need 20", hi_b);
    end
    n_vec++;
    if (hi_a !== 20) begin
      n_err++;
      $display("[TB] FAIL load_beats_decay_a got %0d high cycles, need 20", hi_a);
    end
    led_in = '0;
    step();
  endtask

  task automatic test_bypass();
    logic [15:0] acc;
    en     = 1'b0;
    led_in = 16'hA5A5;
    step();
    n_vec++;
    if (led_out_a !== 16'hA5A5 || led_out_b !== 16'hA5A5) begin
      n_err++;
      $display("[TB] FAIL bypass_pattern got a=%h b=%h, need a5a5", led_out_a, led_out_b);
    end
    en     = 1'b1;
    led_in = '0;
    step();
    acc = '0;
    repeat (15) begin
      step();
      acc = acc | led_out_a | led_out_b;
    end
    n_vec++;
    if (acc !== 16'h0000) begin
      n_err++;
      $display("[TB] FAIL enable_from_zero got %h, need 0000", acc);
    end
  endtask

  task automatic test_reset_mid_fade();
    int guard;
    led_in = 16'h0004;
    step();
    led_in = '0;
    guard = 0;
    while (m_lvl_b[2] != 9 && guard < 60) begin
      step();
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({led_out_a, led_out_b, wrap_a, wrap_b} !== 34'd0) begin
      n_err++;
      $display("[TB] FAIL async_reset got a=%h b=%h wrap=%b%b, need all 0",
               led_out_a, led_out_b, wrap_a, wrap_b);
    end
    #4 rst = 1'b0;
    model_reset();
    count_first_wrap("mid_reset");
  endtask

  task automatic test_gamma();
    int hi_a, hi_b, guard, need;
    logic [15:0] oth;
`ifdef LED_FADE_GAMMA_EN
    need = 4;
`else
    need = 8;
`endif
    led_in = 16'h0080;
    step();
    led_in = '0;
    guard = 0;
    while (m_lvl_a[7] != 8 && guard < 8000) begin
      step();
      guard++;
    end
    wait_wrap("gamma");
    count_high(7, 15, hi_a, hi_b, oth);
    n_vec++;
    if (hi_a !== need) begin
      n_err++;
      $display("[TB] FAIL level8_duty got %0d high cycles, need %0d", hi_a, need);
    end
  endtask

  initial begin
    test_reset();
    test_fade();
    test_underflow();
    test_load_beats_decay();
    test_bypass();
    test_reset_mid_fade();
    test_gamma();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Downstream stage of the running-light controller. It takes the 16-bit one-hot/pattern LED vector produced by the flow-light control stage and drives the physical LEDs with PWM. Each LED that is lit jumps to full brightness, then fades linearly after it goes dark, giving the moving light a comet tail. The block sits between the light-flow control output and the board LED pins.

## Interface
- N_LED, 16, number of LED channels
- BW, 4, brightness width; MAX = 2^BW − 1
- PWM_DIV, 1000, clk cycles per PWM slice (≥1)
- DECAY_DIV, 2_500_000, clk cycles per decay step (≥1)
- DECAY_STEP, 1, brightness decrement per decay step (1..MAX)

- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = fade/PWM mode; 0 = bypass
- led_in  in  N_LED  pattern from the flow-light control stage (1 = lit)
- led_out  out  N_LED  PWM-modulated LED drive, registered
- pwm_wrap  out  1  one-cycle pulse when the PWM slice counter wraps MAX−1→0

## Operation
- Prescaler `pre_cnt` counts 0..PWM_DIV−1; `slice_tick` is asserted when `pre_cnt == PWM_DIV−1`.
- PWM slice counter `pwm_cnt` (BW bits) counts 0..MAX−1 and advances on `slice_tick`. Period = MAX slices. `pwm_wrap` = `slice_tick && pwm_cnt == MAX−1`.
- Decay counter counts 0..DECAY_DIV−1; `decay_tick` is asserted on its terminal count. It runs freely, independent of `en`.
- Per channel, the brightness register `lvl[i]` (BW bits) is updated with this priority:
  - `en == 0` → 0
  - `led_in[i] == 1` → MAX. Load wins over a simultaneous `decay_tick`.
  - `decay_tick` → `lvl − DECAY_STEP`, saturating at 0. No wrap-around below 0.
  - else hold.
- Output, registered:
  - `en == 1` → `led_out[i] = (eff[i] > pwm_cnt)`, where `eff = lvl`.
  - `en == 0` → `led_out[i] = led_in[i]`.
- Consequences of the compare: `lvl == MAX` gives an output that is always high; `lvl == 0` gives an output that is always low; `lvl == k` gives k high slices per period.
- All counters run continuously, including while `en == 0`.

## Timing
- Reset (asynchronous): `pre_cnt`, `pwm_cnt`, the decay counter, all `lvl`, `led_out` and `pwm_wrap` go to 0 immediately. Operation resumes on the first clk edge after `rst` deasserts.
- `led_in[i]` rises before edge k → `lvl[i] = MAX` after edge k → `led_out[i] = 1` after edge k+1. Latency is 2 cycles.
- Bypass mode: `led_out` equals `led_in` delayed by 1 cycle.
- A change in `lvl` during a PWM period takes effect at the next compare. There is no period-boundary double buffering.
- `pwm_wrap` is registered: it is high for the cycle following the wrapping `slice_tick` edge.
- Toggling `en` from 0 to 1: all `lvl` start at 0. Only channels whose `led_in` is high light up.

## Configuration
- `LED_FADE_GAMMA_EN` defined: the compare uses the perceptual curve `eff = (lvl*lvl) >> BW` (2·BW-bit product), with `eff = MAX` forced when `lvl == MAX`.
- `LED_FADE_GAMMA_EN` undefined: `eff = lvl` (linear). No multiplier is instantiated.

## Test plan
Parameters for all tests: BW=4, PWM_DIV=1, DECAY_STEP=1 (MAX=15, PWM period = 15 cycles).
- DECAY_DIV=1000, en=1, one-cycle pulse on `led_in[3]` → `led_out[3]` is high for all 15 cycles of the next full period; after the first `decay_tick` (`lvl` = 14) it is high for 14 of 15 cycles; other channels stay 0.
- DECAY_DIV=4, one-cycle pulse on `led_in[0]` → `lvl[0]` reaches 0 on the 15th `decay_tick` and stays 0 (no underflow to 15); `led_out[0]` is constant 0 afterwards.
- `led_in[5]` held at 1 across a `decay_tick` → `lvl[5]` stays 15 and `led_out[5]` stays constantly 1 (load beats decay).
- en=0, `led_in` = 16'hA5A5 → `led_out` = 16'hA5A5 one cycle later. Then en=1 with `led_in` = 0 → `led_out` = 0 from the second cycle onward.
- Mid-fade (`lvl[2]` = 9), `rst` pulsed for half a cycle → `led_out` = 0 and `pwm_wrap` = 0 with no clock edge; `pwm_cnt` restarts at 0 and the first `pwm_wrap` appears 15 cycles after release.
- `LED_FADE_GAMMA_EN` defined, `lvl` = 8 → 4 high cycles per period. Undefined → 8 high cycles per period. `lvl` = 15 → 15 high cycles in both builds.
